// File: rtl/backward_recursion_block_pkg.sv
// Shared fixed-point defaults, complex sample layout and read-FSM states
// for the control-bounded filter recursion stages.
package backward_recursion_block_pkg;

    localparam int unsigned WIDTH_DEF = 32;
    localparam int unsigned FRAC_DEF  = 16;
    localparam int unsigned DEPTH_DEF = 32;

    // 1.0 in Q(WIDTH-FRAC).FRAC
    localparam int FX_ONE = 1 << FRAC_DEF;

    // Complex sample; real part occupies the upper half of the packed word
    typedef struct packed {
        logic signed [WIDTH_DEF-1:0] r;
        logic signed [WIDTH_DEF-1:0] i;
    } cplx_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        RUN   = 2'd2
    } rd_state_e;

endpackage

// File: rtl/complex_mul_add.sv
// Combinational complex y = F*w + x: full-precision products, floor shift by
// FRAC, truncation to WIDTH, then wrap-around add of x.
module complex_mul_add
    import backward_recursion_block_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned FRAC  = FRAC_DEF
) (
    input  logic [2*WIDTH-1:0] f_i,
    input  logic [2*WIDTH-1:0] w_i,
    input  logic [2*WIDTH-1:0] x_i,
    output logic [2*WIDTH-1:0] y_c_o
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned SW = 2 * WIDTH + 1;

    logic signed [WIDTH-1:0] f_re, f_im, w_re, w_im, x_re, x_im;
    logic signed [PW-1:0]    p_ac, p_bd, p_ad, p_bc;
    logic signed [SW-1:0]    re_full, im_full;
    logic signed [WIDTH-1:0] y_re, y_im;

    assign {f_re, f_im} = f_i;
    assign {w_re, w_im} = w_i;
    assign {x_re, x_im} = x_i;

    assign p_ac = PW'(f_re) * PW'(w_re);
    assign p_bd = PW'(f_im) * PW'(w_im);
    assign p_ad = PW'(f_re) * PW'(w_im);
    assign p_bc = PW'(f_im) * PW'(w_re);

    assign re_full = SW'(p_ac) - SW'(p_bd);
    assign im_full = SW'(p_ad) + SW'(p_bc);

    assign y_re = WIDTH'(re_full >>> FRAC) + x_re;
    assign y_im = WIDTH'(im_full >>> FRAC) + x_im;

    assign y_c_o = {y_re, y_im};

endmodule

// File: rtl/backward_recursion_block.sv
// Anti-causal recursion stage: ping-pong block buffer replayed newest-to-oldest
// through w[k] = F*w[k+1] + x[k], results emitted in reversed order.
module backward_recursion_block
    import backward_recursion_block_pkg::*;
#(
    parameter int unsigned WIDTH     = WIDTH_DEF,
    parameter int unsigned FRAC      = FRAC_DEF,
    parameter int unsigned DEPTH     = DEPTH_DEF,
    parameter int          FACTOR_RE = 0,
    parameter int          FACTOR_IM = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [2*WIDTH-1:0] in_data,
    output logic               out_valid,
    output logic [2*WIDTH-1:0] out_data,
    output logic               out_last,
    output logic               overflow
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = 2 * WIDTH;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [CW-1:0] FACTOR    = {WIDTH'(FACTOR_RE), WIDTH'(FACTOR_IM)};

    logic [CW-1:0] mem_q [2][DEPTH];
    logic [CW-1:0] rdata_q;

    rd_state_e     state_q, state_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic          wb_q, wb_d;
    logic          pending_q, pending_d;
    logic          ovf_q, ovf_d;
    logic          rbank_q, rbank_d;
    logic [AW-1:0] raddr_q, raddr_d;
    logic [CW-1:0] w_q, w_d;
    logic          out_valid_q, out_valid_d;
    logic          out_last_q, out_last_d;
    logic [CW-1:0] out_data_q, out_data_d;

    logic          complete_c;
    logic          rd_bank_c;
    logic [AW-1:0] rd_addr_c;
    logic [CW-1:0] mac_c;

    complex_mul_add #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) u_mac (
        .f_i   (FACTOR),
        .w_i   (w_q),
        .x_i   (rdata_q),
        .y_c_o (mac_c)
    );

    // Write side: fill the current bank, flip banks on the last sample of a block
    assign complete_c = in_valid && (wptr_q == LAST_ADDR);
    assign wptr_d     = in_valid ? wptr_q + AW'(1) : wptr_q;
    assign wb_d       = wb_q ^ complete_c;

    // Read FSM; a queued block is prefetched during out_last so blocks chain without a gap
    always_comb begin
        state_d     = state_q;
        rbank_d     = rbank_q;
        raddr_d     = raddr_q;
        w_d         = w_q;
        pending_d   = pending_q | complete_c;
        ovf_d       = ovf_q | (complete_c & pending_q);
        rd_bank_c   = rbank_q;
        rd_addr_c   = raddr_q;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        out_data_d  = out_data_q;

        case (state_q)
            IDLE: begin
                if (complete_c || pending_q) begin
                    state_d   = FETCH;
                    rbank_d   = complete_c ? wb_q : ~wb_q;
                    raddr_d   = LAST_ADDR;
                    w_d       = '0;
                    pending_d = 1'b0;
                end
            end
            FETCH: begin
                state_d = RUN;
            end
            RUN: begin
                out_valid_d = 1'b1;
                out_data_d  = mac_c;
                w_d         = mac_c;
                raddr_d     = raddr_q - AW'(1);
                rd_addr_c   = raddr_q - AW'(1);
                if (raddr_q == '0) begin
                    out_last_d = 1'b1;
                    w_d        = '0;
                    raddr_d    = LAST_ADDR;
                    if (complete_c) begin
                        // last sample lands in RAM this edge; needs a FETCH cycle
                        state_d   = FETCH;
                        rbank_d   = wb_q;
                        pending_d = 1'b0;
                    end else if (pending_q) begin
                        state_d   = RUN;
                        rbank_d   = ~wb_q;
                        rd_bank_c = ~wb_q;
                        rd_addr_c = LAST_ADDR;
                        pending_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wptr_q      <= '0;
            wb_q        <= 1'b0;
            pending_q   <= 1'b0;
            ovf_q       <= 1'b0;
            rbank_q     <= 1'b0;
            raddr_q     <= LAST_ADDR;
            w_q         <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            wptr_q      <= wptr_d;
            wb_q        <= wb_d;
            pending_q   <= pending_d;
            ovf_q       <= ovf_d;
            rbank_q     <= rbank_d;
            raddr_q     <= raddr_d;
            w_q         <= w_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
        end
    end

    // Ping-pong storage with registered read port
    always_ff @(posedge clk) begin
        if (in_valid) begin
            mem_q[wb_q][wptr_q] <= in_data;
        end
        rdata_q <= mem_q[rd_bank_c][rd_addr_c];
    end

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_data  = out_data_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_backward_recursion_block.sv
// Directed bench: four instances (DEPTH=4) with different recursion factors.
module tb_backward_recursion_block;
    import backward_recursion_block_pkg::*;

    localparam int unsigned W = 32;
    localparam int FRE [4] = '{32768, 0, 65536, -32768};
    localparam int FIM [4] = '{0, 32768, 0, 0};

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         vin  [4];
    logic [2*W-1:0] din  [4];
    logic         vout [4];
    logic [2*W-1:0] dout [4];
    logic         lout [4];
    logic         ovf  [4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        backward_recursion_block #(
            .WIDTH     (32),
            .FRAC      (16),
            .DEPTH     (4),
            .FACTOR_RE (FRE[g]),
            .FACTOR_IM (FIM[g])
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (vin[g]),
            .in_data   (din[g]),
            .out_valid (vout[g]),
            .out_data  (dout[g]),
            .out_last  (lout[g]),
            .overflow  (ovf[g])
        );
    end

    task automatic push(input int n, input logic [31:0] re, input logic [31:0] im);
        @(negedge clk);
        vin[n] = 1'b1;
        din[n] = {re, im};
    endtask

    task automatic stop(input int n);
        @(negedge clk);
        vin[n] = 1'b0;
        din[n] = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 4; n++) begin
            checks++;
            if (vout[n] !== 1'b0 || lout[n] !== 1'b0 || ovf[n] !== 1'b0 || dout[n] !== '0) begin
                errors++;
                $display("FAIL reset[%0d] got v=%b l=%b o=%b d=%h want 0 0 0 0", n, vout[n], lout[n], ovf[n], dout[n]);
            end
        end
    endtask

    task automatic test_decay();
        logic [31:0] er [4] = '{32'd65536, 32'd32768, 32'd16384, 32'd8192};
        push(0, 0, 0); push(0, 0, 0); push(0, 0, 0); push(0, 32'(FX_ONE), 0);
        stop(0);
        checks++;
        if (vout[0] !== 1'b0) begin errors++; $display("FAIL decay_lat0 got %b want 0", vout[0]); end
        @(negedge clk);
        checks++;
        if (vout[0] !== 1'b0) begin errors++; $display("FAIL decay_lat1 got %b want 0", vout[0]); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (vout[0] !== 1'b1 || lout[0] !== (k == 3)) begin
                errors++;
                $display("FAIL decay_ctl[%0d] got v=%b l=%b want v=1 l=%b", k, vout[0], lout[0], k == 3);
            end
            checks++;
            if (dout[0] !== {er[k], 32'd0}) begin
                errors++;
                $display("FAIL decay_data[%0d] got %h want %h", k, dout[0], {er[k], 32'd0});
            end
        end
        @(negedge clk);
        checks++;
        if (vout[0] !== 1'b0) begin errors++; $display("FAIL decay_end got %b want 0", vout[0]); end
    endtask

    task automatic test_rotate();
        logic [31:0] er [4] = '{32'd65536, 32'd0, -32'sd16384, 32'd0};
        logic [31:0] ei [4] = '{32'd0, 32'd32768, 32'd0, -32'sd8192};
        push(1, 0, 0); push(1, 0, 0); push(1, 0, 0); push(1, 32'(FX_ONE), 0);
        stop(1);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (vout[1] !== 1'b1 || lout[1] !== (k == 3) || dout[1] !== {er[k], ei[k]}) begin
                errors++;
                $display("FAIL rotate[%0d] got v=%b l=%b d=%h want v=1 l=%b d=%h", k, vout[1], lout[1], dout[1], k == 3, {er[k], ei[k]});
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] er [4] = '{32'h7FFF0000, 32'h80010000, 32'h80010000, 32'h80010000};
        push(2, 0, 0); push(2, 0, 0); push(2, 32'h00020000, 0); push(2, 32'h7FFF0000, 0);
        stop(2);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (vout[2] !== 1'b1 || dout[2] !== {er[k], 32'd0}) begin
                errors++;
                $display("FAIL wrap[%0d] got v=%b d=%h want v=1 d=%h", k, vout[2], dout[2], {er[k], 32'd0});
            end
        end
    endtask

    task automatic test_floor();
        logic [31:0] er [4] = '{32'd3, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFF};
        push(3, 0, 0); push(3, 0, 0); push(3, 0, 0); push(3, 32'd3, 0);
        stop(3);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (vout[3] !== 1'b1 || dout[3] !== {er[k], 32'd0}) begin
                errors++;
                $display("FAIL floor[%0d] got v=%b d=%h want v=1 d=%h", k, vout[3], dout[3], {er[k], 32'd0});
            end
        end
    endtask

    task automatic test_back_to_back();
        int   cnt   = 0;
        int   lasts = 0;
        int   gaps  = 0;
        logic prev  = 1'b0;
        fork
            begin
                for (int b = 0; b < 3; b++) begin
                    for (int j = 0; j < 4; j++) begin
                        push(0, (j == 3) ? 32'((b + 1) * FX_ONE) : 32'd0, 0);
                    end
                end
                stop(0);
            end
            begin
                for (int cyc = 0; cyc < 30; cyc++) begin
                    @(negedge clk);
                    if (vout[0] === 1'b1) begin
                        logic [31:0] ev;
                        if (cnt > 0 && !prev) gaps++;
                        ev = 32'((cnt / 4 + 1) * FX_ONE) >> (cnt % 4);
                        checks++;
                        if (cnt >= 12 || dout[0] !== {ev, 32'd0} || lout[0] !== (cnt % 4 == 3)) begin
                            errors++;
                            $display("FAIL b2b_out[%0d] got d=%h l=%b want d=%h l=%b", cnt, dout[0], lout[0], {ev, 32'd0}, cnt % 4 == 3);
                        end
                        if (lout[0] === 1'b1) lasts++;
                        cnt++;
                    end
                    prev = vout[0];
                end
            end
        join
        checks++;
        if (cnt != 12 || lasts != 3 || gaps != 0) begin
            errors++;
            $display("FAIL b2b_stream got cnt=%0d lasts=%0d gaps=%0d want 12 3 0", cnt, lasts, gaps);
        end
        checks++;
        if (ovf[0] !== 1'b0) begin errors++; $display("FAIL b2b_ovf got %b want 0", ovf[0]); end
    endtask

    task automatic test_reset_mid();
        int spurious = 0;
        push(0, 0, 0); push(0, 0, 0); push(0, 0, 0); push(0, 32'(FX_ONE), 0);
        push(0, 0, 0); push(0, 0, 0);
        stop(0);
        checks++;
        if (vout[0] !== 1'b1 || dout[0] !== {32'd65536, 32'd0}) begin
            errors++; $display("FAIL rmid_out0 got v=%b d=%h want v=1 d=%h", vout[0], dout[0], {32'd65536, 32'd0});
        end
        @(negedge clk);
        checks++;
        if (vout[0] !== 1'b1 || dout[0] !== {32'd32768, 32'd0}) begin
            errors++; $display("FAIL rmid_out1 got v=%b d=%h want v=1 d=%h", vout[0], dout[0], {32'd32768, 32'd0});
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (vout[0] !== 1'b0 || dout[0] !== '0 || lout[0] !== 1'b0) begin
            errors++; $display("FAIL rmid_cleared got v=%b l=%b d=%h want 0 0 0", vout[0], lout[0], dout[0]);
        end
        push(0, 0, 0); push(0, 0, 0); push(0, 0, 0);
        stop(0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (vout[0] !== 1'b0) spurious++;
        end
        checks++;
        if (spurious != 0) begin errors++; $display("FAIL rmid_partial got %0d outputs want 0", spurious); end
        push(0, 32'(FX_ONE), 0);
        stop(0);
        @(negedge clk);
        checks++;
        if (vout[0] !== 1'b0) begin errors++; $display("FAIL rmid_lat1 got %b want 0", vout[0]); end
        @(negedge clk);
        checks++;
        if (vout[0] !== 1'b1 || dout[0] !== {32'd65536, 32'd0}) begin
            errors++; $display("FAIL rmid_fresh got v=%b d=%h want v=1 d=%h", vout[0], dout[0], {32'd65536, 32'd0});
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_overflow();
        @(negedge clk);
        force g_dut[3].u_dut.state_q = FETCH;
        for (int i = 0; i < 8; i++) begin
            push(3, 32'(i), 0);
            if (i == 4) begin
                checks++;
                if (ovf[3] !== 1'b0) begin errors++; $display("FAIL ovf_first got %b want 0", ovf[3]); end
            end
        end
        stop(3);
        checks++;
        if (ovf[3] !== 1'b1) begin errors++; $display("FAIL ovf_second got %b want 1", ovf[3]); end
        release g_dut[3].u_dut.state_q;
        repeat (12) @(negedge clk);
        checks++;
        if (ovf[3] !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", ovf[3]); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (ovf[3] !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b want 0", ovf[3]); end
    endtask

    initial begin
        for (int n = 0; n < 4; n++) begin
            vin[n] = 1'b0;
            din[n] = '0;
        end
        test_reset();
        test_decay();
        test_rotate();
        test_wrap();
        test_floor();
        test_back_to_back();
        test_reset_mid();
        test_overflow();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
